// File: rtl/decode_ctrl_pipe.sv
// rtl/decode_ctrl_pipe.sv - decode control, ID/EX control register and mult/div occupancy tracker
module decode_ctrl_pipe #(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_d,
    input  logic [OP_W-1:0]    op_code,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               stall_e,
    input  logic               flush_e,
    output logic               valid_e,
    output logic               reg_write_e,
    output logic               mem_write_e,
    output logic               alu_src_e,
    output logic               ext_op_e,
    output logic               jump_e,
    output logic               branch_e,
    output logic               illegal_e,
    output logic [1:0]         mem_to_reg_e,
    output logic [1:0]         reg_dst_e,
    output logic [1:0]         alu_op_e,
    output logic               md_start_e,
    output logic               md_busy,
    output logic               md_done,
    output logic               stall_d
);

    localparam logic [OP_W-1:0]    OP_ROP  = OP_W'(6'h00);
    localparam logic [OP_W-1:0]    OP_LW   = OP_W'(6'h23);
    localparam logic [OP_W-1:0]    OP_SW   = OP_W'(6'h2B);
    localparam logic [OP_W-1:0]    OP_BEQ  = OP_W'(6'h04);
    localparam logic [OP_W-1:0]    OP_ADDI = OP_W'(6'h08);
    localparam logic [OP_W-1:0]    OP_J    = OP_W'(6'h02);
    localparam logic [OP_W-1:0]    OP_JAL  = OP_W'(6'h03);
    localparam logic [OP_W-1:0]    OP_LWR  = OP_W'(6'h26);
    localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'(6'h18);
    localparam logic [FUNCT_W-1:0] F_DIV   = FUNCT_W'(6'h1A);
    localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(6'h10);
    localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(6'h12);

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       ext_op;
        logic       jump;
        logic       branch;
        logic       illegal;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic [1:0] alu_op;
        logic       md_start;
    } ctrl_t;

    typedef enum logic {IDLE, BUSY} state_t;

    ctrl_t            dec;
    ctrl_t            ctrl_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             md_dep, md_hazard, capture;

    always_comb begin
        dec = '0;
        if (valid_d) begin
            dec.valid = 1'b1;
            case (op_code)
                OP_ROP: begin
                    dec.reg_dst = 2'b01;
                    dec.alu_op  = 2'b10;
                    if (funct == F_MULT || funct == F_DIV) dec.md_start = 1'b1;
                    else                                   dec.reg_write = 1'b1;
                end
                OP_LW: begin
                    dec.reg_write  = 1'b1;
                    dec.mem_to_reg = 2'b01;
                    dec.alu_src    = 1'b1;
                    dec.ext_op     = 1'b1;
                end
                OP_SW: begin
                    dec.mem_write = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.ext_op    = 1'b1;
                end
                OP_BEQ: begin
                    dec.branch = 1'b1;
                    dec.alu_op = 2'b01;
                    dec.ext_op = 1'b1;
                end
                OP_ADDI: begin
                    dec.reg_write = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.ext_op    = 1'b1;
                end
                OP_J: dec.jump = 1'b1;
                OP_JAL: begin
                    dec.jump       = 1'b1;
                    dec.reg_write  = 1'b1;
                    dec.reg_dst    = 2'b10;
                    dec.mem_to_reg = 2'b10;
                end
                OP_LWR: begin
                    dec.reg_write  = 1'b1;
                    dec.reg_dst    = 2'b01;
                    dec.mem_to_reg = 2'b01;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
    end

    // Anything touching HI/LO or starting a new op must wait for the unit to drain.
    assign md_dep    = valid_d && (op_code == OP_ROP) &&
                       (funct == F_MULT || funct == F_DIV || funct == F_MFHI || funct == F_MFLO);
    assign md_hazard = md_busy && md_dep;
    assign stall_d   = stall_e || md_hazard;
    assign capture   = !flush_e && !stall_e && !md_hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else if (flush_e) begin
            ctrl_q <= '0;
        end else if (!stall_e) begin
            ctrl_q <= md_hazard ? '0 : dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Only the capture edge starts the unit; a MULT parked in E by stall_e does not retrigger.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture && dec.md_start) begin
                    state_d = BUSY;
                    cnt_d   = (funct == F_DIV) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign md_busy      = (state_q == BUSY);
    assign md_done      = done_q;
    assign valid_e      = ctrl_q.valid;
    assign reg_write_e  = ctrl_q.reg_write;
    assign mem_write_e  = ctrl_q.mem_write;
    assign alu_src_e    = ctrl_q.alu_src;
    assign ext_op_e     = ctrl_q.ext_op;
    assign jump_e       = ctrl_q.jump;
    assign branch_e     = ctrl_q.branch;
    assign illegal_e    = ctrl_q.illegal;
    assign mem_to_reg_e = ctrl_q.mem_to_reg;
    assign reg_dst_e    = ctrl_q.reg_dst;
    assign alu_op_e     = ctrl_q.alu_op;
    assign md_start_e   = ctrl_q.md_start;

endmodule
